// File: rtl/network_div_pkg.sv
// Shared constants for the network divider: default widths, FSM state encodings and saturation limits.
package network_div_pkg;

  localparam int DIVIDEND_W_DEF = 29;
  localparam int DIVISOR_W_DEF  = 13;
  localparam int QUOT_W_DEF     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Largest positive magnitude representable in a qw-bit signed quotient.
  function automatic logic [63:0] sat_pos_lim(input int qw);
    return (64'd1 << (qw - 1)) - 64'd1;
  endfunction

  // Largest negative magnitude representable in a qw-bit signed quotient.
  function automatic logic [63:0] sat_neg_lim(input int qw);
    return 64'd1 << (qw - 1);
  endfunction

endpackage

// File: rtl/network_div_29s_13ns_16s_sat.sv
// Sign-magnitude to QUOT_W two's-complement saturator; ovf_o flags a clipped result.
module network_div_sat
  import network_div_pkg::*;
#(
  parameter int MAG_W  = DIVIDEND_W_DEF + 1,
  parameter int QUOT_W = QUOT_W_DEF
) (
  input  logic                     neg_i,
  input  logic [MAG_W-1:0]         mag_i,
  output logic signed [QUOT_W-1:0] value_o,
  output logic                     ovf_o
);

  localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(sat_pos_lim(QUOT_W));
  localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(sat_neg_lim(QUOT_W));

  logic [QUOT_W-1:0] mag_lo;

  always_comb begin
    mag_lo = mag_i[QUOT_W-1:0];
    ovf_o  = neg_i ? (mag_i > NEG_LIM) : (mag_i > POS_LIM);
    if (neg_i) begin
      value_o = ovf_o ? {1'b1, {(QUOT_W-1){1'b0}}} : (~mag_lo + QUOT_W'(1));
    end else begin
      value_o = ovf_o ? {1'b0, {(QUOT_W-1){1'b1}}} : mag_lo;
    end
  end

endmodule

// File: rtl/network_div_29s_13ns_16s.sv
// Sequential radix-2 restoring signed/unsigned divider with saturated quotient and valid/ready handshakes.
// Optional round-to-nearest quotient under macro NETWORK_DIV_ROUND_EN.
module network_div_29s_13ns_16s
  import network_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF,
  parameter int QUOT_W     = QUOT_W_DEF
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DIVIDEND_W-1:0]  dividend,
  input  logic        [DIVISOR_W-1:0]   divisor,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [QUOT_W-1:0]      quotient,
  output logic signed [DIVISOR_W:0]     remainder,
  output logic                          ovf,
  output logic                          div_by_zero
);

  localparam int MAG_W = DIVIDEND_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W);

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         sgn_q, sgn_d;
  logic [DIVIDEND_W-1:0]        dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]         div_q, div_d;
  logic [DIVISOR_W-1:0]         prem_q, prem_d;
  logic signed [QUOT_W-1:0]     quot_q, quot_d;
  logic signed [DIVISOR_W:0]    rem_q, rem_d;
  logic                         ovf_q, ovf_d;
  logic                         dbz_q, dbz_d;

  logic                         accept;
  logic [DIVIDEND_W-1:0]        dvd_abs;
  logic [DIVISOR_W:0]           trial;
  logic                         ge;
  logic                         div0;
  logic [MAG_W-1:0]             qmag;
  logic [MAG_W-1:0]             sat_mag;
  logic signed [QUOT_W-1:0]     sat_val;
  logic                         sat_ovf;
  logic signed [DIVISOR_W:0]    rem_mag;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  // Unsigned DIVIDEND_W bits hold 2^(DIVIDEND_W-1), so the most negative dividend needs no extra bit.
  assign dvd_abs = dividend[DIVIDEND_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
  assign trial   = {prem_q, dvd_q[DIVIDEND_W-1]};
  assign ge      = (trial >= {1'b0, div_q});
  assign div0    = (div_q == '0);
  assign rem_mag = {1'b0, prem_q};

`ifdef NETWORK_DIV_ROUND_EN
  assign qmag = {1'b0, dvd_q} + MAG_W'({prem_q, 1'b0} >= {1'b0, div_q});
`else
  assign qmag = {1'b0, dvd_q};
`endif

  // An all-ones magnitude forces the saturator to the signed limit for divide-by-zero.
  assign sat_mag = div0 ? '1 : qmag;

  network_div_sat #(
    .MAG_W  (MAG_W),
    .QUOT_W (QUOT_W)
  ) u_sat (
    .neg_i   (sgn_q),
    .mag_i   (sat_mag),
    .value_o (sat_val),
    .ovf_o   (sat_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sgn_d   = dividend[DIVIDEND_W-1];
          dvd_d   = dvd_abs;
          div_d   = divisor;
          prem_d  = '0;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
          state_d = (divisor == '0) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        // Quotient bits shift into dvd_q as dividend bits shift out of it.
        prem_d = ge ? DIVISOR_W'(trial - {1'b0, div_q}) : trial[DIVISOR_W-1:0];
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], ge};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        quot_d  = sat_val;
        ovf_d   = sat_ovf;
        dbz_d   = div0;
        rem_d   = sgn_q ? -rem_mag : rem_mag;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    sgn_q  <= sgn_d;
    dvd_q  <= dvd_d;
    div_q  <= div_d;
    prem_q <= prem_d;
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_network_div_29s_13ns_16s.sv
// Scoreboard bench for network_div_29s_13ns_16s; honours NETWORK_DIV_ROUND_EN in its reference model.
module tb_network_div_29s_13ns_16s;

  typedef struct {
    logic signed [15:0] q;
    logic signed [13:0] r;
    logic               ovf;
    logic               dbz;
  } res_t;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [28:0] dividend = '0;
  logic [12:0]        divisor = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] quotient;
  logic signed [13:0] remainder;
  logic               ovf;
  logic               div_by_zero;

  int   n_cmp = 0;
  int   n_fail = 0;
  res_t exp_q[$];

  network_div_29s_13ns_16s dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: truncating division, optional round-half-away, then 16-bit saturation.
  function automatic res_t model(input longint a, input longint b);
    res_t   e;
    longint q, r, ra;
    if (b == 0) begin
      e.q = (a < 0) ? -16'sd32768 : 16'sd32767;
      e.r = '0; e.ovf = 1'b1; e.dbz = 1'b1;
      return e;
    end
    q = a / b;
    r = a % b;
    ra = (r < 0) ? -r : r;
`ifdef NETWORK_DIV_ROUND_EN
    if (2 * ra >= b) q = (a < 0) ? q - 1 : q + 1;
`endif
    e.dbz = 1'b0;
    if (q > 32767) begin e.q = 16'sd32767; e.ovf = 1'b1; end
    else if (q < -32768) begin e.q = -16'sd32768; e.ovf = 1'b1; end
    else begin e.q = 16'(q); e.ovf = 1'b0; end
    e.r = 14'(r);
    return e;
  endfunction

  // Drives one operand pair, records the expected result, waits for out_valid and captures outputs.
  task automatic run_op(input logic signed [28:0] a, input logic [12:0] b, input bit rel,
                        output int lat, output res_t got);
    bit tmo;
    exp_q.push_back(model(longint'(a), longint'(b)));
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    lat = 1; tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin tmo = 1'b0; break; end
      @(posedge ap_clk); #1;
      lat++;
    end
    if (tmo) begin n_cmp++; n_fail++; $display("FAIL out_valid_timeout: got none after %0d edges want 31 or 2", lat); end
    got.q = quotient; got.r = remainder; got.ovf = ovf; got.dbz = div_by_zero;
    if (rel) begin
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (quotient !== 16'sd0) begin n_fail++; $display("FAIL rst_quotient: got %0d want 0", quotient); end
    n_cmp++; if (remainder !== 14'sd0) begin n_fail++; $display("FAIL rst_remainder: got %0d want 0", remainder); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b want 0", ovf); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %0b want 0", div_by_zero); end
    #3 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    longint ta[8] = '{1000, -1000, -268435456, 268435455, -229376, 98304, 21, -21};
    longint tb[8] = '{7, 7, 1, 8191, 7, 3, 6, 6};
    int   lat;
    res_t got, e;
    for (int i = 0; i < 8; i++) begin
      run_op(29'(ta[i]), 13'(tb[i]), 1'b1, lat, got);
      e = exp_q.pop_front();
      n_cmp++; if (lat !== 31) begin n_fail++; $display("FAIL basic%0d_latency: got %0d want 31", i, lat); end
      n_cmp++; if (got.q !== e.q) begin n_fail++; $display("FAIL basic%0d_quotient: got %0d want %0d", i, got.q, e.q); end
      n_cmp++; if (got.r !== e.r) begin n_fail++; $display("FAIL basic%0d_remainder: got %0d want %0d", i, got.r, e.r); end
      n_cmp++; if (got.ovf !== e.ovf) begin n_fail++; $display("FAIL basic%0d_ovf: got %0b want %0b", i, got.ovf, e.ovf); end
      n_cmp++; if (got.dbz !== e.dbz) begin n_fail++; $display("FAIL basic%0d_dbz: got %0b want %0b", i, got.dbz, e.dbz); end
    end
  endtask

  task automatic test_div_zero();
    longint ta[3] = '{500, -500, 0};
    int   lat;
    res_t got, e;
    for (int i = 0; i < 3; i++) begin
      run_op(29'(ta[i]), 13'd0, 1'b1, lat, got);
      e = exp_q.pop_front();
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL dz%0d_latency: got %0d want 2", i, lat); end
      n_cmp++; if (got.q !== e.q) begin n_fail++; $display("FAIL dz%0d_quotient: got %0d want %0d", i, got.q, e.q); end
      n_cmp++; if (got.r !== e.r) begin n_fail++; $display("FAIL dz%0d_remainder: got %0d want %0d", i, got.r, e.r); end
      n_cmp++; if (got.ovf !== e.ovf) begin n_fail++; $display("FAIL dz%0d_ovf: got %0b want %0b", i, got.ovf, e.ovf); end
      n_cmp++; if (got.dbz !== e.dbz) begin n_fail++; $display("FAIL dz%0d_dbz: got %0b want %0b", i, got.dbz, e.dbz); end
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    res_t got, e;
    run_op(29'sd1000, 13'd7, 1'b0, lat, got);
    e = exp_q.pop_front();
    n_cmp++; if (got.q !== e.q) begin n_fail++; $display("FAIL bp_quotient: got %0d want %0d", got.q, e.q); end
    n_cmp++; if (got.r !== e.r) begin n_fail++; $display("FAIL bp_remainder: got %0d want %0d", got.r, e.r); end
    dividend = 29'sd77; divisor = 13'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %0b want 1", i, out_valid); end
      n_cmp++; if (quotient !== e.q) begin n_fail++; $display("FAIL bp_hold_q%0d: got %0d want %0d", i, quotient, e.q); end
      n_cmp++; if (remainder !== e.r) begin n_fail++; $display("FAIL bp_hold_r%0d: got %0d want %0d", i, remainder, e.r); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %0b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_idle: got %0b want 1", in_ready); end
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: got %0b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_calc();
    int   lat;
    res_t got, e;
    dividend = 29'sd1000; divisor = 13'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %0b want 0", out_valid); end
    n_cmp++; if (quotient !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_quotient: got %0d want 0", quotient); end
    n_cmp++; if (remainder !== 14'sd0) begin n_fail++; $display("FAIL mid_rst_remainder: got %0d want 0", remainder); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf: got %0b want 0", ovf); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dbz: got %0b want 0", div_by_zero); end
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready: got %0b want 1", in_ready); end
    run_op(29'sd1000, 13'd7, 1'b1, lat, got);
    e = exp_q.pop_front();
    n_cmp++; if (lat !== 31) begin n_fail++; $display("FAIL mid_rst_next_latency: got %0d want 31", lat); end
    n_cmp++; if (got.q !== e.q) begin n_fail++; $display("FAIL mid_rst_next_quotient: got %0d want %0d", got.q, e.q); end
    n_cmp++; if (got.r !== e.r) begin n_fail++; $display("FAIL mid_rst_next_remainder: got %0d want %0d", got.r, e.r); end
  endtask

  task automatic test_back_to_back();
    int                 lat;
    res_t               got, e;
    logic signed [28:0] a;
    logic [12:0]        b;
    for (int i = 0; i < 24; i++) begin
      a = 29'($urandom);
      if (i % 3 == 0) a = 29'(int'($urandom_range(0, 400000)) - 200000);
      b = 13'($urandom);
      if (i % 7 == 3) b = 13'd0;
      run_op(a, b, 1'b1, lat, got);
      e = exp_q.pop_front();
      n_cmp++; if (got.q !== e.q) begin n_fail++; $display("FAIL b2b%0d_quotient: %0d/%0d got %0d want %0d", i, a, b, got.q, e.q); end
      n_cmp++; if (got.r !== e.r) begin n_fail++; $display("FAIL b2b%0d_remainder: %0d/%0d got %0d want %0d", i, a, b, got.r, e.r); end
      n_cmp++; if (got.ovf !== e.ovf) begin n_fail++; $display("FAIL b2b%0d_ovf: got %0b want %0b", i, got.ovf, e.ovf); end
      n_cmp++; if (got.dbz !== e.dbz) begin n_fail++; $display("FAIL b2b%0d_dbz: got %0b want %0b", i, got.dbz, e.dbz); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
